seq_mul_div_8: RTL and testbench

Iterative 8-bit unsigned multiplier/divider that produces a 16-bit result for one input of the ULA's 16-way, 16-bit result multiplexer. Operands are captured on a start request. The block runs 8 single-bit iterations and holds the result stable until the next accepted start. The mux output path stays combinational; this block is the only multi-cycle operation source feeding it.

---
 rtl/seq_mul_div_8.sv | 133 +++++++++++++
 tb/tb_seq_mul_div_8.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_div_8.sv
// Iterative 8-bit unsigned multiplier / restoring divider.
// Produces a 16-bit result after 8 single-bit iterations.
module seq_mul_div_8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        div_by_zero,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  dvd_q, dvd_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [15:0] result_q, result_d;
  logic        dbz_q, dbz_d;

  logic [15:0] mul_sum;
  logic [9:0]  rem_shift;
  logic [9:0]  rem_diff;
  logic        borrow;
  logic [8:0]  rem_next;
  logic [7:0]  quo_next;

  // One iteration of each algorithm; both run every RUN cycle and op picks the result.
  always_comb begin
    mul_sum   = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
    rem_shift = {rem_q, dvd_q[7]};
    rem_diff  = rem_shift - {2'b00, divisor_q};
    borrow    = rem_diff[9];
    rem_next  = borrow ? rem_shift[8:0] : rem_diff[8:0];
    quo_next  = {dvd_q[6:0], ~borrow};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    dbz_d     = dbz_q;

    case (state_q)
      S_RUN: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        rem_d    = rem_next;
        dvd_d    = quo_next;
        if (cnt_q == 3'd7) begin
          state_d  = S_DONE;
          result_d = op_q ? {rem_next[7:0], quo_next} : mul_sum;
          dbz_d    = op_q && (divisor_q == 8'h00);
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation.
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = 3'd0;
          op_d      = op;
          acc_d     = 16'h0000;
          mcand_d   = {8'h00, a};
          mplier_d  = b;
          rem_d     = 9'h000;
          dvd_d     = a;
          divisor_d = b;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      op_q      <= 1'b0;
      acc_q     <= 16'h0000;
      mcand_q   <= 16'h0000;
      mplier_q  <= 8'h00;
      rem_q     <= 9'h000;
      dvd_q     <= 8'h00;
      divisor_q <= 8'h00;
      result_q  <= 16'h0000;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_mul_div_8.sv
// Scoreboard bench for seq_mul_div_8: directed cases from the test plan plus
// randomized operations checked against an arithmetic reference model.
module tb_seq_mul_div_8;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  seq_mul_div_8 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // {div_by_zero, result}
  logic [16:0] exp_q[$];
  logic [15:0] last_res = 16'h0000;
  logic        last_dbz = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input logic o, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r;
    logic        z;
    if (!o) begin
      r = 16'(x) * 16'(y);
      z = 1'b0;
    end else if (y == 8'h00) begin
      r = {x, 8'hFF};
      z = 1'b1;
    end else begin
      r = {8'(x % y), 8'(x / y)};
      z = 1'b0;
    end
    return {z, r};
  endfunction

  // driver tasks: issue is called at a negedge where the DUT can accept
  task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
    op    = $urandom_range(0, 1);
  endtask

  // returns at the negedge where done is high; checks the busy span
  task automatic wait_done(input int pre_busy);
    int nb;
    bit seen;
    nb   = pre_busy;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) nb++;
    end
    check("done_seen", {15'b0, seen}, 16'h0001);
    check("busy_cycles", 16'(nb), 16'd8);
  endtask

  // monitor: pops the scoreboard whenever done is presented
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("busy_done_excl", {15'b0, busy & done}, 16'h0000);
        if (done) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got result 0x%04h expected no done at %0t", result, $time);
          end else begin
            e = exp_q.pop_front();
            check("result", result, e[15:0]);
            check("div_by_zero", {15'b0, div_by_zero}, {15'b0, e[16]});
            last_res = e[15:0];
            last_dbz = e[16];
          end
        end else begin
          check("result_hold", result, last_res);
          check("dbz_hold", {15'b0, div_by_zero}, {15'b0, last_dbz});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, result, 16'h0000);
    check({tag, "_busy"}, {15'b0, busy}, 16'h0000);
    check({tag, "_done"}, {15'b0, done}, 16'h0000);
    check({tag, "_dbz"}, {15'b0, div_by_zero}, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    #2 reset = 1'b0;
    @(negedge clk);

    // max multiply
    issue(1'b0, 8'hFF, 8'hFF);
    wait_done(0);
    @(negedge clk);
    // divide 200 / 7
    issue(1'b1, 8'hC8, 8'h07);
    wait_done(0);
    @(negedge clk);
    // divide by zero, then multiply clears the flag
    issue(1'b1, 8'h35, 8'h00);
    wait_done(0);
    @(negedge clk);
    issue(1'b0, 8'h02, 8'h03);
    wait_done(0);
    @(negedge clk);

    // start pulsed mid-run is ignored
    issue(1'b0, 8'h03, 8'h05);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 8'h99;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3);
    // back-to-back accept from DONE
    issue(1'b0, 8'h10, 8'h10);
    wait_done(0);
    @(negedge clk);

    // reset mid-run, between edges
    issue(1'b1, 8'hB7, 8'h0D);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid_run");
    exp_q.delete();
    last_res = 16'h0000;
    last_dbz = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (12) @(negedge clk);
    issue(1'b0, 8'h0A, 8'h0B);
    wait_done(0);

    // randomized operations, mixing back-to-back and idle gaps
    for (int n = 0; n < 40; n++) begin
      logic       o;
      logic [7:0] x;
      logic [7:0] y;
      o = $urandom_range(0, 1);
      x = $urandom_range(0, 255);
      y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(o, x, y);
      wait_done(0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
